// File: rtl/arm_banked_regfile_pkg.sv
// ---------------------------------------------------------------------------
// arm_banked_regfile_pkg
// Shared definitions for the mode-aware ARM register file:
//   - processor mode encodings (CPSR[4:0])
//   - physical storage indices for the 37-entry backing store
//   - CPSR bit positions
//   - helpers: logical->physical mapping, SPSR index lookup, exception-entry CPSR
// No ports (package).
// ---------------------------------------------------------------------------
package arm_banked_regfile_pkg;

    typedef enum logic [4:0] {
        MODE_USR = 5'h10,
        MODE_FIQ = 5'h11,
        MODE_IRQ = 5'h12,
        MODE_SVC = 5'h13,
        MODE_ABT = 5'h17,
        MODE_UND = 5'h1B,
        MODE_SYS = 5'h1F
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SAVE,
        ST_ENTER
    } seq_state_e;

    localparam int NUM_PHYS = 37;

    localparam logic [5:0] PHYS_PC       = 6'd15;
    localparam logic [5:0] PHYS_FIQ_R8   = 6'd16;
    localparam logic [5:0] PHYS_SVC_R13  = 6'd23;
    localparam logic [5:0] PHYS_ABT_R13  = 6'd25;
    localparam logic [5:0] PHYS_IRQ_R13  = 6'd27;
    localparam logic [5:0] PHYS_UND_R13  = 6'd29;
    localparam logic [5:0] PHYS_CPSR     = 6'd31;
    localparam logic [5:0] PHYS_SPSR_FIQ = 6'd32;
    localparam logic [5:0] PHYS_SPSR_SVC = 6'd33;
    localparam logic [5:0] PHYS_SPSR_ABT = 6'd34;
    localparam logic [5:0] PHYS_SPSR_IRQ = 6'd35;
    localparam logic [5:0] PHYS_SPSR_UND = 6'd36;

    localparam int CPSR_N     = 31;
    localparam int CPSR_Z     = 30;
    localparam int CPSR_C     = 29;
    localparam int CPSR_V     = 28;
    localparam int CPSR_I     = 7;
    localparam int CPSR_F     = 6;
    localparam int CPSR_T     = 5;
    localparam int CPSR_M_MSB = 4;
    localparam int CPSR_M_LSB = 0;

    // Modes that own an SPSR and can be targeted by exception entry.
    function automatic logic is_exc_mode(input logic [4:0] mode);
        return (mode == MODE_FIQ) || (mode == MODE_IRQ) || (mode == MODE_SVC) ||
               (mode == MODE_ABT) || (mode == MODE_UND);
    endfunction

    // Only meaningful when is_exc_mode(mode) is true; callers gate on that.
    function automatic logic [5:0] spsr_index(input logic [4:0] mode);
        logic [5:0] idx;
        idx = PHYS_SPSR_SVC;
        case (mode)
            MODE_FIQ: idx = PHYS_SPSR_FIQ;
            MODE_SVC: idx = PHYS_SPSR_SVC;
            MODE_ABT: idx = PHYS_SPSR_ABT;
            MODE_IRQ: idx = PHYS_SPSR_IRQ;
            MODE_UND: idx = PHYS_SPSR_UND;
            default:  idx = PHYS_SPSR_SVC;
        endcase
        return idx;
    endfunction

    // FIQ banks r8-r14; the other privileged modes bank only r13/r14.
    // Unknown encodings and SYS fall through to the user copies.
    function automatic logic [5:0] map_phys(input logic [3:0] idx, input logic [4:0] mode);
        logic [5:0] phys;
        logic [5:0] lr_off;
        lr_off = (idx == 4'd14) ? 6'd1 : 6'd0;
        phys   = {2'b00, idx};
        if ((mode == MODE_FIQ) && (idx >= 4'd8) && (idx <= 4'd14)) begin
            phys = PHYS_FIQ_R8 + {2'b00, idx} - 6'd8;
        end else if ((idx == 4'd13) || (idx == 4'd14)) begin
            case (mode)
                MODE_SVC: phys = PHYS_SVC_R13 + lr_off;
                MODE_ABT: phys = PHYS_ABT_R13 + lr_off;
                MODE_IRQ: phys = PHYS_IRQ_R13 + lr_off;
                MODE_UND: phys = PHYS_UND_R13 + lr_off;
                default:  phys = {2'b00, idx};
            endcase
        end
        return phys;
    endfunction

    // CPSR value committed when an exception is taken: new mode, IRQs masked,
    // FIQs additionally masked only for FIQ entry, ARM state.
    function automatic logic [31:0] enter_cpsr(input logic [31:0] cpsr, input logic [4:0] mode);
        logic [31:0] nxt;
        nxt = cpsr;
        nxt[CPSR_M_MSB:CPSR_M_LSB] = mode;
        nxt[CPSR_I] = 1'b1;
        if (mode == MODE_FIQ) begin
            nxt[CPSR_F] = 1'b1;
        end
        nxt[CPSR_T] = 1'b0;
        return nxt;
    endfunction

endpackage

// File: rtl/arm_banked_regfile_if.sv
// ---------------------------------------------------------------------------
// arm_banked_regfile_if
// Bundles every non-clock/reset signal of the register file.
//   master : decode/execute side (drives requests, reads results)
//   slave  : the register file itself
// Signals: rd_addr/rd_data (NUM_RD ports), GPR write, PC write/read,
// masked CPSR write/read, SPSR write/read, exception entry/return, busy.
// ---------------------------------------------------------------------------
interface arm_banked_regfile_if #(
    parameter int NUM_RD = 3
);
    logic [NUM_RD*4-1:0]  rd_addr;
    logic [NUM_RD*32-1:0] rd_data;
    logic                 wr_en;
    logic [3:0]           wr_addr;
    logic [31:0]          wr_data;
    logic                 pc_wr_en;
    logic [31:0]          pc_wr_data;
    logic [31:0]          pc_rd;
    logic                 cpsr_wr_en;
    logic [31:0]          cpsr_wr_data;
    logic [31:0]          cpsr_wr_mask;
    logic [31:0]          cpsr_rd;
    logic                 spsr_wr_en;
    logic [31:0]          spsr_wr_data;
    logic [31:0]          spsr_rd;
    logic                 exc_req;
    logic [4:0]           exc_mode;
    logic [31:0]          exc_vector;
    logic [31:0]          exc_ret_addr;
    logic                 exc_ack;
    logic                 eret_req;
    logic                 busy;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, pc_wr_en, pc_wr_data,
               cpsr_wr_en, cpsr_wr_data, cpsr_wr_mask, spsr_wr_en, spsr_wr_data,
               exc_req, exc_mode, exc_vector, exc_ret_addr, eret_req,
        input  rd_data, pc_rd, cpsr_rd, spsr_rd, exc_ack, busy
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, pc_wr_en, pc_wr_data,
               cpsr_wr_en, cpsr_wr_data, cpsr_wr_mask, spsr_wr_en, spsr_wr_data,
               exc_req, exc_mode, exc_vector, exc_ret_addr, eret_req,
        output rd_data, pc_rd, cpsr_rd, spsr_rd, exc_ack, busy
    );
endinterface

// File: rtl/arm_banked_regfile_reg_map.sv
// ---------------------------------------------------------------------------
// arm_banked_regfile_reg_map
// Combinational translation of a logical register index under a given mode
// into the physical storage index.
//   idx  in  4  logical register r0-r15
//   mode in  5  processor mode (CPSR[4:0])
//   phys out 6  physical index into the 37-entry store
// ---------------------------------------------------------------------------
module arm_banked_regfile_reg_map
    import arm_banked_regfile_pkg::*;
(
    input  logic [3:0] idx,
    input  logic [4:0] mode,
    output logic [5:0] phys
);

    assign phys = map_phys(idx, mode);

endmodule

// File: rtl/arm_banked_regfile.sv
// ---------------------------------------------------------------------------
// arm_banked_regfile
// Mode-aware ARM register file with exception entry/return sequencer.
//   clk    in  single clock, all state changes on the rising edge
//   reset  in  synchronous active-high reset
//   bus    slave modport of arm_banked_regfile_if:
//          NUM_RD registered read ports, one GPR write port, PC port,
//          masked CPSR write, current-mode SPSR access, exc_req/exc_ack,
//          eret_req and busy.
// Parameters: NUM_RD, RESET_PC, RESET_CPSR.
// ---------------------------------------------------------------------------
module arm_banked_regfile
    import arm_banked_regfile_pkg::*;
#(
    parameter int          NUM_RD     = 3,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] RESET_CPSR = 32'h0000_00D3
) (
    input  logic                  clk,
    input  logic                  reset,
    arm_banked_regfile_if.slave   bus
);

    logic [31:0]          regs_q [NUM_PHYS];
    logic [31:0]          regs_d [NUM_PHYS];
    logic [NUM_RD*32-1:0] rd_data_q, rd_data_d;
    seq_state_e           state_q, state_d;
    logic [4:0]           exc_mode_q, exc_mode_d;
    logic [31:0]          exc_vector_q, exc_vector_d;
    logic [31:0]          exc_ret_q, exc_ret_d;
    logic                 exc_ack_q, exc_ack_d;
    logic                 busy_q, busy_d;

    logic [4:0]           cur_mode;
    logic                 cur_has_spsr;
    logic [5:0]           cur_spsr_idx;
    logic [5:0]           wr_phys;
    logic [5:0]           rd_phys [NUM_RD];

    // Banking always follows the CPSR committed before this edge, so a
    // same-edge mode change never redirects this edge's reads or writes.
    assign cur_mode     = regs_q[PHYS_CPSR][CPSR_M_MSB:CPSR_M_LSB];
    assign cur_has_spsr = is_exc_mode(cur_mode);
    assign cur_spsr_idx = spsr_index(cur_mode);

    arm_banked_regfile_reg_map u_wr_map (
        .idx  (bus.wr_addr),
        .mode (cur_mode),
        .phys (wr_phys)
    );

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd_map
        arm_banked_regfile_reg_map u_rd_map (
            .idx  (bus.rd_addr[4*k +: 4]),
            .mode (cur_mode),
            .phys (rd_phys[k])
        );
    end

    // Next-state for storage and sequencer. While the sequencer runs, all
    // external writes are dropped; an accepted exc_req also drops the writes
    // presented alongside it.
    always_comb begin
        regs_d       = regs_q;
        state_d      = state_q;
        exc_mode_d   = exc_mode_q;
        exc_vector_d = exc_vector_q;
        exc_ret_d    = exc_ret_q;
        exc_ack_d    = 1'b0;
        busy_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.exc_req && is_exc_mode(bus.exc_mode)) begin
                    exc_mode_d   = bus.exc_mode;
                    exc_vector_d = bus.exc_vector;
                    exc_ret_d    = bus.exc_ret_addr;
                    state_d      = ST_SAVE;
                    busy_d       = 1'b1;
                end else begin
                    if (bus.wr_en && !(bus.pc_wr_en && (bus.wr_addr == 4'd15))) begin
                        regs_d[wr_phys] = bus.wr_data;
                    end
                    if (bus.pc_wr_en) begin
                        regs_d[PHYS_PC] = bus.pc_wr_data;
                    end
                    if (bus.eret_req) begin
                        if (cur_has_spsr) begin
                            regs_d[PHYS_CPSR] = regs_q[cur_spsr_idx];
                        end
                    end else if (bus.cpsr_wr_en) begin
                        regs_d[PHYS_CPSR] = (regs_q[PHYS_CPSR] & ~bus.cpsr_wr_mask) |
                                            (bus.cpsr_wr_data & bus.cpsr_wr_mask);
                    end
                    if (bus.spsr_wr_en && cur_has_spsr) begin
                        regs_d[cur_spsr_idx] = bus.spsr_wr_data;
                    end
                end
            end
            ST_SAVE: begin
                regs_d[spsr_index(exc_mode_q)]     = regs_q[PHYS_CPSR];
                regs_d[map_phys(4'd14, exc_mode_q)] = exc_ret_q;
                state_d   = ST_ENTER;
                exc_ack_d = 1'b1;
                busy_d    = 1'b1;
            end
            ST_ENTER: begin
                regs_d[PHYS_CPSR] = enter_cpsr(regs_q[PHYS_CPSR], exc_mode_q);
                regs_d[PHYS_PC]   = exc_vector_q;
                state_d           = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Reads take the post-edge value, giving write-first bypass.
        rd_data_d = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            rd_data_d[32*k +: 32] = regs_d[rd_phys[k]];
        end
    end

    // All state, including the registered read data and sequencer outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_PHYS; i++) begin
                regs_q[i] <= '0;
            end
            regs_q[PHYS_PC]   <= RESET_PC;
            regs_q[PHYS_CPSR] <= RESET_CPSR;
            rd_data_q    <= '0;
            state_q      <= ST_IDLE;
            exc_mode_q   <= '0;
            exc_vector_q <= '0;
            exc_ret_q    <= '0;
            exc_ack_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            regs_q       <= regs_d;
            rd_data_q    <= rd_data_d;
            state_q      <= state_d;
            exc_mode_q   <= exc_mode_d;
            exc_vector_q <= exc_vector_d;
            exc_ret_q    <= exc_ret_d;
            exc_ack_q    <= exc_ack_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.rd_data = rd_data_q;
    assign bus.pc_rd   = regs_q[PHYS_PC];
    assign bus.cpsr_rd = regs_q[PHYS_CPSR];
    assign bus.spsr_rd = cur_has_spsr ? regs_q[cur_spsr_idx] : 32'h0;
    assign bus.exc_ack = exc_ack_q;
    assign bus.busy    = busy_q;

endmodule

// File: tb/tb_arm_banked_regfile.sv
// ---------------------------------------------------------------------------
// tb_arm_banked_regfile
// Scoreboard bench for arm_banked_regfile: each step queues the values the
// outputs must hold after the next rising edge, then one edge is applied and
// the queue is drained against the sampled outputs.
// ---------------------------------------------------------------------------
module tb_arm_banked_regfile;

    localparam int SEL_RD0  = 0;
    localparam int SEL_RD1  = 1;
    localparam int SEL_RD2  = 2;
    localparam int SEL_PC   = 3;
    localparam int SEL_CPSR = 4;
    localparam int SEL_SPSR = 5;
    localparam int SEL_BUSY = 6;
    localparam int SEL_ACK  = 7;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] value;
    } expect_t;

    logic    clk;
    logic    reset;
    expect_t sb_queue[$];
    int      error_count = 0;
    int      check_count = 0;

    arm_banked_regfile_if #(.NUM_RD(3)) bus ();

    arm_banked_regfile #(
        .NUM_RD     (3),
        .RESET_PC   (32'h0000_0000),
        .RESET_CPSR (32'h0000_00D3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            SEL_RD0:  return bus.rd_data[31:0];
            SEL_RD1:  return bus.rd_data[63:32];
            SEL_RD2:  return bus.rd_data[95:64];
            SEL_PC:   return bus.pc_rd;
            SEL_CPSR: return bus.cpsr_rd;
            SEL_SPSR: return bus.spsr_rd;
            SEL_BUSY: return {31'b0, bus.busy};
            SEL_ACK:  return {31'b0, bus.exc_ack};
            default:  return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    task automatic expectValue(input string tag, input int sel, input logic [31:0] value);
        expect_t e;
        e.tag   = tag;
        e.sel   = sel;
        e.value = value;
        sb_queue.push_back(e);
    endtask

    task automatic clearStrobes();
        bus.wr_en        = 1'b0;
        bus.wr_addr      = 4'd0;
        bus.wr_data      = 32'h0;
        bus.pc_wr_en     = 1'b0;
        bus.pc_wr_data   = 32'h0;
        bus.cpsr_wr_en   = 1'b0;
        bus.cpsr_wr_data = 32'h0;
        bus.cpsr_wr_mask = 32'h0;
        bus.spsr_wr_en   = 1'b0;
        bus.spsr_wr_data = 32'h0;
        bus.exc_req      = 1'b0;
        bus.exc_mode     = 5'h0;
        bus.exc_vector   = 32'h0;
        bus.exc_ret_addr = 32'h0;
        bus.eret_req     = 1'b0;
    endtask

    // One rising edge, then compare everything queued for it.
    task automatic applyStimulus();
        expect_t e;
        @(posedge clk);
        #1;
        while (sb_queue.size() > 0) begin
            e = sb_queue.pop_front();
            checkOutput(e.tag, observe(e.sel), e.value);
        end
        clearStrobes();
    endtask

    task automatic setReads(input logic [3:0] r0, input logic [3:0] r1, input logic [3:0] r2);
        bus.rd_addr = {r2, r1, r0};
    endtask

    task automatic writeGpr(input logic [3:0] addr, input logic [31:0] data);
        bus.wr_en   = 1'b1;
        bus.wr_addr = addr;
        bus.wr_data = data;
    endtask

    task automatic writeCpsr(input logic [31:0] data, input logic [31:0] mask);
        bus.cpsr_wr_en   = 1'b1;
        bus.cpsr_wr_data = data;
        bus.cpsr_wr_mask = mask;
    endtask

    task automatic raiseExc(input logic [4:0] mode, input logic [31:0] vec, input logic [31:0] ret);
        bus.exc_req      = 1'b1;
        bus.exc_mode     = mode;
        bus.exc_vector   = vec;
        bus.exc_ret_addr = ret;
    endtask

    initial begin
        reset = 1'b1;
        clearStrobes();
        setReads(4'd0, 4'd0, 4'd0);

        // Reset values
        expectValue("rst_pc", SEL_PC, 32'h0);
        expectValue("rst_cpsr", SEL_CPSR, 32'hD3);
        expectValue("rst_rd0", SEL_RD0, 32'h0);
        expectValue("rst_rd1", SEL_RD1, 32'h0);
        expectValue("rst_rd2", SEL_RD2, 32'h0);
        expectValue("rst_spsr", SEL_SPSR, 32'h0);
        expectValue("rst_busy", SEL_BUSY, 32'h0);
        expectValue("rst_ack", SEL_ACK, 32'h0);
        applyStimulus();
        reset = 1'b0;

        // SVC r13 banking
        setReads(4'd13, 4'd14, 4'd15);
        writeGpr(4'd13, 32'h1111);
        expectValue("svc_r13_bypass", SEL_RD0, 32'h1111);
        expectValue("svc_r14", SEL_RD1, 32'h0);
        expectValue("svc_r15", SEL_RD2, 32'h0);
        applyStimulus();

        writeCpsr(32'h10, 32'h1F);
        expectValue("to_usr_cpsr", SEL_CPSR, 32'hD0);
        expectValue("r13_prev_mode", SEL_RD0, 32'h1111);
        applyStimulus();

        bus.eret_req = 1'b1;
        expectValue("usr_eret_cpsr", SEL_CPSR, 32'hD0);
        expectValue("usr_r13", SEL_RD0, 32'h0);
        expectValue("usr_spsr", SEL_SPSR, 32'h0);
        applyStimulus();

        writeCpsr(32'h13, 32'h1F);
        expectValue("to_svc_cpsr", SEL_CPSR, 32'hD3);
        expectValue("r13_still_usr", SEL_RD0, 32'h0);
        applyStimulus();

        expectValue("svc_r13_back", SEL_RD0, 32'h1111);
        applyStimulus();

        // FIQ r8 banking
        setReads(4'd8, 4'd14, 4'd15);
        writeCpsr(32'h11, 32'h1F);
        expectValue("to_fiq_cpsr", SEL_CPSR, 32'hD1);
        expectValue("svc_r8", SEL_RD0, 32'h0);
        applyStimulus();

        writeGpr(4'd8, 32'hAA);
        expectValue("fiq_r8_bypass", SEL_RD0, 32'hAA);
        applyStimulus();

        writeCpsr(32'h10, 32'h1F);
        expectValue("fiq_r8_hold", SEL_RD0, 32'hAA);
        applyStimulus();

        writeCpsr(32'h12, 32'h1F);
        expectValue("usr_r8", SEL_RD0, 32'h0);
        expectValue("to_irq_cpsr", SEL_CPSR, 32'hD2);
        applyStimulus();

        writeCpsr(32'h13, 32'h1F);
        expectValue("irq_r8", SEL_RD0, 32'h0);
        expectValue("svc_again_cpsr", SEL_CPSR, 32'hD3);
        applyStimulus();

        // PC port beats GPR write to r15
        writeGpr(4'd15, 32'h5);
        bus.pc_wr_en   = 1'b1;
        bus.pc_wr_data = 32'h9;
        expectValue("pc_prio", SEL_PC, 32'h9);
        expectValue("r15_read", SEL_RD2, 32'h9);
        applyStimulus();

        // Write-first bypass; also clear I/F ahead of the exception
        setReads(4'd3, 4'd14, 4'd15);
        writeGpr(4'd3, 32'h7);
        writeCpsr(32'h0, 32'hC0);
        expectValue("r3_bypass", SEL_RD0, 32'h7);
        expectValue("cpsr_clear_if", SEL_CPSR, 32'h13);
        applyStimulus();

        // IRQ entry from SVC; the same-edge GPR write is dropped
        raiseExc(5'h12, 32'h18, 32'h104);
        writeGpr(4'd3, 32'h99);
        expectValue("irq_busy1", SEL_BUSY, 32'h1);
        expectValue("irq_ack1", SEL_ACK, 32'h0);
        expectValue("irq_drop_wr", SEL_RD0, 32'h7);
        expectValue("irq_cpsr1", SEL_CPSR, 32'h13);
        applyStimulus();

        bus.pc_wr_en   = 1'b1;
        bus.pc_wr_data = 32'h77;
        expectValue("irq_busy2", SEL_BUSY, 32'h1);
        expectValue("irq_ack2", SEL_ACK, 32'h1);
        expectValue("irq_pc_busy", SEL_PC, 32'h9);
        applyStimulus();

        expectValue("irq_busy3", SEL_BUSY, 32'h0);
        expectValue("irq_ack3", SEL_ACK, 32'h0);
        expectValue("irq_cpsr", SEL_CPSR, 32'h92);
        expectValue("irq_pc", SEL_PC, 32'h18);
        expectValue("irq_spsr", SEL_SPSR, 32'h13);
        expectValue("svc_lr", SEL_RD1, 32'h0);
        applyStimulus();

        expectValue("irq_lr", SEL_RD1, 32'h104);
        applyStimulus();

        // eret restores CPSR from SPSR_irq and beats a CPSR write
        bus.eret_req = 1'b1;
        writeCpsr(32'h0, 32'hFFFF_FFFF);
        expectValue("eret_cpsr", SEL_CPSR, 32'h13);
        applyStimulus();

        // Invalid target mode is ignored; same-edge write still lands
        setReads(4'd4, 4'd14, 4'd13);
        raiseExc(5'h1F, 32'h40, 32'h50);
        writeGpr(4'd4, 32'h44);
        expectValue("bad_mode_busy", SEL_BUSY, 32'h0);
        expectValue("bad_mode_wr", SEL_RD0, 32'h44);
        applyStimulus();

        // FIQ entry sets F as well
        setReads(4'd8, 4'd14, 4'd13);
        raiseExc(5'h11, 32'h1C, 32'h300);
        expectValue("fiq_busy1", SEL_BUSY, 32'h1);
        applyStimulus();
        expectValue("fiq_ack", SEL_ACK, 32'h1);
        applyStimulus();
        expectValue("fiq_cpsr", SEL_CPSR, 32'hD1);
        expectValue("fiq_pc", SEL_PC, 32'h1C);
        expectValue("fiq_spsr", SEL_SPSR, 32'h13);
        expectValue("fiq_busy3", SEL_BUSY, 32'h0);
        expectValue("svc_view_r8", SEL_RD0, 32'h0);
        applyStimulus();
        expectValue("fiq_r8", SEL_RD0, 32'hAA);
        expectValue("fiq_lr", SEL_RD1, 32'h300);
        expectValue("fiq_r13", SEL_RD2, 32'h0);
        applyStimulus();

        // Reset during SAVE aborts the sequence
        setReads(4'd3, 4'd14, 4'd13);
        raiseExc(5'h13, 32'h8, 32'h200);
        expectValue("abort_busy1", SEL_BUSY, 32'h1);
        applyStimulus();

        reset = 1'b1;
        expectValue("abort_busy", SEL_BUSY, 32'h0);
        expectValue("abort_ack", SEL_ACK, 32'h0);
        expectValue("abort_pc", SEL_PC, 32'h0);
        expectValue("abort_cpsr", SEL_CPSR, 32'hD3);
        expectValue("abort_spsr", SEL_SPSR, 32'h0);
        applyStimulus();
        reset = 1'b0;

        expectValue("post_ack", SEL_ACK, 32'h0);
        expectValue("post_busy", SEL_BUSY, 32'h0);
        expectValue("post_r3", SEL_RD0, 32'h0);
        expectValue("post_svc_lr", SEL_RD1, 32'h0);
        expectValue("post_svc_r13", SEL_RD2, 32'h0);
        expectValue("post_cpsr", SEL_CPSR, 32'hD3);
        applyStimulus();

        // eret in USR has no effect
        writeCpsr(32'h10, 32'h1F);
        expectValue("usr2_cpsr", SEL_CPSR, 32'hD0);
        applyStimulus();
        bus.eret_req = 1'b1;
        expectValue("usr2_eret", SEL_CPSR, 32'hD0);
        expectValue("usr2_spsr", SEL_SPSR, 32'h0);
        applyStimulus();

        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

endmodule
